pipe_hazard_ctrl: RTL and testbench

Stall/flush controller for the five-stage MIPS pipeline. It drives the enable and reset inputs of the F/D and D/E pipeline registers and the PC enable. It compares decode-stage operand needs (Tuse) against result availability (Tnew) in E and M, and tracks the multiply/divide unit's busy window with an internal countdown. A stall freezes PC and F/D for one cycle and inserts a bubble into D/E; the decision is recomputed every cycle.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 54 +++++
 rtl/pipe_hazard_ctrl.sv | 76 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline encodings for the stall/flush controller: Tuse/Tnew codes,
// multiply/divide latency defaults and the hardwired-zero register index.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int T_W   = 2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [T_W-1:0] TUSE_0    = 2'd0;
  localparam logic [T_W-1:0] TUSE_1    = 2'd1;
  localparam logic [T_W-1:0] TUSE_2    = 2'd2;
  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [T_W-1:0] TNEW_0 = 2'd0;
  localparam logic [T_W-1:0] TNEW_1 = 2'd1;
  localparam logic [T_W-1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// HI/LO busy window tracker: counts down the remaining mult/div latency after
// a start seen in E. Only built when PIPE_HAZARD_CTRL_MD_EN is defined.
module md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_start,
  input  logic e_md_div,
  output logic md_busy
);

  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start always (re)loads the counter, even while already busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (e_md_start) begin
      state_d = MD_BUSY;
      cnt_d   = e_md_div ? DIV_LD : MULT_LD;
    end else if (state_q == MD_BUSY) begin
      if (cnt_q == CW'(1)) begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    md_busy = e_md_start | (state_q == MD_BUSY);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Tuse/Tnew hazard compare
// on rs/rt plus optional HI/LO busy stall (enabled by PIPE_HAZARD_CTRL_MD_EN).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [T_W-1:0]   d_rs_tuse,
  input  logic [T_W-1:0]   d_rt_tuse,
  input  logic [REG_W-1:0] e_wa,
  input  logic [REG_W-1:0] m_wa,
  input  logic [T_W-1:0]   e_tnew,
  input  logic [T_W-1:0]   m_tnew,
  input  logic             d_md_use,
  input  logic             e_md_start,
  input  logic             e_md_div,
  output logic             pc_en,
  output logic             fd_en,
  output logic             de_clr,
  output logic             md_busy,
  output logic             stall
);

  // The E producer is younger than M, so a match in E shadows any match in M.
  function automatic logic src_hazard(
    input logic [REG_W-1:0] src,
    input logic [T_W-1:0]   tuse,
    input logic [REG_W-1:0] ewa,
    input logic [T_W-1:0]   etn,
    input logic [REG_W-1:0] mwa,
    input logic [T_W-1:0]   mtn
  );
    if (src == REG_ZERO) return 1'b0;
    if (src == ewa)      return etn > tuse;
    if (src == mwa)      return mtn > tuse;
    return 1'b0;
  endfunction

  logic rs_hazard, rt_hazard, md_busy_raw, md_stall, stall_raw;

  assign rs_hazard = src_hazard(d_rs, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
  assign rt_hazard = src_hazard(d_rt, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);

`ifdef PIPE_HAZARD_CTRL_MD_EN
  md_busy_timer #(
    .MULT_CYC(MULT_CYC),
    .DIV_CYC (DIV_CYC)
  ) u_md_busy_timer (
    .clk       (clk),
    .reset     (reset),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .md_busy   (md_busy_raw)
  );
  assign md_stall = d_md_use & md_busy_raw;
`else
  logic unused_md;
  assign unused_md   = ^{clk, d_md_use, e_md_start, e_md_div} ^ (MULT_CYC != DIV_CYC);
  assign md_busy_raw = 1'b0;
  assign md_stall    = 1'b0;
`endif

  // Reset forces the pipeline free-running and hides any in-flight busy window.
  assign stall_raw = rs_hazard | rt_hazard | md_stall;
  assign stall     = ~reset & stall_raw;
  assign md_busy   = ~reset & md_busy_raw;
  assign pc_en     = ~stall;
  assign fd_en     = ~stall;
  assign de_clr    = stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; MD expectations follow PIPE_HAZARD_CTRL_MD_EN.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, e_wa, m_wa;
  logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic       d_md_use, e_md_start, e_md_div;
  logic       pc_en, fd_en, de_clr, md_busy, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_tuse (d_rs_tuse),
    .d_rt_tuse (d_rt_tuse),
    .e_wa      (e_wa),
    .m_wa      (m_wa),
    .e_tnew    (e_tnew),
    .m_tnew    (m_tnew),
    .d_md_use  (d_md_use),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_clr    (de_clr),
    .md_busy   (md_busy),
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic exp_stall, input logic exp_busy);
    logic [4:0] obs, expv;
    #1;
    obs  = {pc_en, fd_en, de_clr, stall, md_busy};
    expv = {~exp_stall, ~exp_stall, exp_stall, exp_stall, exp_busy};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s {pc_en,fd_en,de_clr,stall,md_busy} observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 0; d_rt = 0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    e_wa = 0; m_wa = 0; e_tnew = 0; m_tnew = 0;
    d_md_use = 0; e_md_start = 0; e_md_div = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    // hazardous inputs while in reset must still give forced outputs
    d_rs = 1; d_rs_tuse = 1; e_wa = 1; e_tnew = 2; e_md_start = 1; d_md_use = 1;
    chk("reset_forced", 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("idle", 1'b0, 1'b0);
    tick();

    // load-use: lw in E, addu in D reading rs
    d_rs = 1; d_rs_tuse = 1; e_wa = 1; e_tnew = 2;
    chk("lw_e_rs", 1'b1, 1'b0);
    tick();
    e_wa = 0; e_tnew = 0; m_wa = 1; m_tnew = 2;
    chk("m_tnew2_rs", 1'b1, 1'b0);
    tick();
    m_tnew = 1;
    chk("m_tnew_eq_tuse", 1'b0, 1'b0);
    tick();
    m_tnew = 0;
    chk("m_tnew0", 1'b0, 1'b0);
    tick();

    idle_inputs();
    d_rt = 0; d_rt_tuse = 0; e_wa = 0; e_tnew = 2;
    chk("rt_zero_reg", 1'b0, 1'b0);
    tick();
    d_rt = 7; d_rt_tuse = 0; e_wa = 7; e_tnew = 1;
    chk("rt_e_hazard", 1'b1, 1'b0);
    tick();
    idle_inputs();
    d_rt = 9; d_rt_tuse = 1; m_wa = 9; m_tnew = 2;
    chk("rt_m_hazard", 1'b1, 1'b0);
    tick();
    idle_inputs();
    d_rs = 3; d_rs_tuse = 0; e_wa = 3; e_tnew = 0; m_wa = 3; m_tnew = 2;
    chk("e_shadows_m", 1'b0, 1'b0);
    tick();
    idle_inputs();
    d_rs = 5; d_rs_tuse = 2'd3; e_wa = 5; e_tnew = 2;
    chk("tuse_none", 1'b0, 1'b0);
    tick();
    idle_inputs();
    d_rs = 6; d_rs_tuse = 0; e_wa = 4; e_tnew = 2; m_wa = 8; m_tnew = 2;
    chk("no_match", 1'b0, 1'b0);
    tick();

`ifdef PIPE_HAZARD_CTRL_MD_EN
    // mult: busy t..t+5 with d_md_use held
    idle_inputs();
    e_md_start = 1; d_md_use = 1;
    chk("mult_start", 1'b1, 1'b1);
    tick();
    e_md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("mult_busy_%0d", i), 1'b1, 1'b1);
      tick();
    end
    chk("mult_done", 1'b0, 1'b0);
    tick();

    // div: busy t..t+10 without a consumer
    idle_inputs();
    e_md_start = 1; e_md_div = 1;
    chk("div_start", 1'b0, 1'b1);
    tick();
    e_md_start = 0; e_md_div = 0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("div_busy_%0d", i), 1'b0, 1'b1);
      tick();
    end
    chk("div_done", 1'b0, 1'b0);
    tick();

    // div interrupted by reset on the 4th busy cycle
    e_md_start = 1; e_md_div = 1; d_md_use = 1;
    chk("divr_start", 1'b1, 1'b1);
    tick();
    e_md_start = 0; e_md_div = 0;
    chk("divr_busy_1", 1'b1, 1'b1);
    tick();
    chk("divr_busy_2", 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    chk("divr_in_reset", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("divr_after_reset", 1'b0, 1'b0);
    tick();

    // load-use and md stall overlap; load clears first
    idle_inputs();
    e_md_start = 1; d_md_use = 1; d_rs = 1; d_rs_tuse = 1; e_wa = 1; e_tnew = 2;
    chk("combo_start", 1'b1, 1'b1);
    tick();
    e_md_start = 0; e_wa = 0; e_tnew = 0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("combo_md_%0d", i), 1'b1, 1'b1);
      tick();
    end
    chk("combo_done", 1'b0, 1'b0);
    tick();

    // restart while busy reloads the counter (mult at t, div at t+2)
    idle_inputs();
    e_md_start = 1;
    chk("reload_mult", 1'b0, 1'b1);
    tick();
    e_md_start = 0;
    chk("reload_mid", 1'b0, 1'b1);
    tick();
    e_md_start = 1; e_md_div = 1;
    chk("reload_div", 1'b0, 1'b1);
    tick();
    e_md_start = 0; e_md_div = 0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("reload_busy_%0d", i), 1'b0, 1'b1);
      tick();
    end
    chk("reload_done", 1'b0, 1'b0);
    tick();
`else
    // without the MD unit the mult/div inputs are inert
    idle_inputs();
    e_md_start = 1; e_md_div = 1; d_md_use = 1;
    chk("nomd_start", 1'b0, 1'b0);
    tick();
    e_md_start = 0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("nomd_after_%0d", i), 1'b0, 1'b0);
      tick();
    end
    d_rs = 2; d_rs_tuse = 0; e_wa = 2; e_tnew = 1;
    chk("nomd_rs_hazard", 1'b1, 1'b0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
